trap_ctrl: RTL and testbench

- Machine-mode trap sequencer sitting between the commit stage and the CSR register file.
- Prioritises pending interrupts (ext/sft/tmr) and synchronous exceptions at the commit boundary, then drives the CSR trap-entry writes (mepc, mcause, mtval, mstatus MIE/MPIE).
- Redirects fetch to the trap vector, and sequences mret by pulsing the CSR mret enable and redirecting to mepc.

---
 rtl/trap_ctrl.sv | 152 +++++++++++++++
 tb/tb_trap_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer between commit and the CSR file
module trap_ctrl #(
    parameter int XLEN     = 64,
    parameter int EXT_SYNC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ext_irq_i,
    input  logic            sft_irq_i,
    input  logic            tmr_irq_i,
    input  logic            meie_i,
    input  logic            msie_i,
    input  logic            mtie_i,
    input  logic            glb_irq_i,
    input  logic            cmt_valid_i,
    input  logic [XLEN-1:0] cmt_pc_i,
    input  logic            exp_valid_i,
    input  logic [3:0]      exp_code_i,
    input  logic [XLEN-1:0] exp_tval_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            kill_o,
    output logic            stall_o,
    output logic            trap_enter_o,
    output logic            mret_ena_o,
    output logic            mepc_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mcause_we_o,
    output logic [XLEN-1:0] mcause_o,
    output logic            mtval_we_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [2:0]      mip_o
);

    typedef enum logic [1:0] {IDLE, SAVE, JUMP, MRET} state_t;

    state_t            state, state_nxt;
    logic              ext_s;
    logic              ext_pend, sft_pend, tmr_pend;
    logic              irq_take, trap_take, mret_take, kill_raw;
    logic [3:0]        irq_code;
    logic              lat_irq;
    logic [3:0]        lat_code;
    logic [XLEN-1:0]   lat_pc;
    logic [XLEN-1:0]   lat_tval;

    generate
        if (EXT_SYNC == 0) begin : g_nosync
            assign ext_s = ext_irq_i;
        end else begin : g_sync
            logic [EXT_SYNC-1:0] sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync <= '0;
                end else begin
                    sync[0] <= ext_irq_i;
                    for (int i = 1; i < EXT_SYNC; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end
            assign ext_s = sync[EXT_SYNC-1];
        end
    endgenerate

    assign ext_pend = ext_s & meie_i;
    assign sft_pend = sft_irq_i & msie_i;
    assign tmr_pend = tmr_irq_i & mtie_i;

    // Interrupts preempt the committing instruction's own exception/mret.
    assign irq_take  = glb_irq_i & (ext_pend | sft_pend | tmr_pend);
    assign trap_take = (state == IDLE) & cmt_valid_i & (irq_take | exp_valid_i);
    assign mret_take = (state == IDLE) & cmt_valid_i & ~trap_take & mret_i;
    assign kill_raw  = trap_take | mret_take;
    assign irq_code  = ext_pend ? 4'd11 : (sft_pend ? 4'd3 : 4'd7);

    // Combinational outputs are gated so they read 0 while reset is held.
    assign kill_o = kill_raw & rst_n;
    assign mip_o  = {ext_s, tmr_irq_i, sft_irq_i} & {3{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_irq  <= 1'b0;
            lat_code <= '0;
            lat_pc   <= '0;
            lat_tval <= '0;
        end else begin
            state <= state_nxt;
            if (trap_take) begin
                lat_irq  <= irq_take;
                lat_code <= irq_take ? irq_code : exp_code_i;
                lat_pc   <= cmt_pc_i;
                lat_tval <= irq_take ? '0 : exp_tval_i;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_o       = 1'b0;
        trap_enter_o  = 1'b0;
        mret_ena_o    = 1'b0;
        mepc_we_o     = 1'b0;
        mepc_o        = '0;
        mcause_we_o   = 1'b0;
        mcause_o      = '0;
        mtval_we_o    = 1'b0;
        mtval_o       = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (state)
            IDLE: begin
                if (trap_take) begin
                    state_nxt = SAVE;
                end else if (mret_take) begin
                    state_nxt = MRET;
                end
            end
            SAVE: begin
                stall_o      = 1'b1;
                trap_enter_o = 1'b1;
                mepc_we_o    = 1'b1;
                mepc_o       = {lat_pc[XLEN-1:1], 1'b0};
                mcause_we_o  = 1'b1;
                mcause_o     = {lat_irq, {(XLEN-5){1'b0}}, lat_code};
                mtval_we_o   = 1'b1;
                mtval_o      = lat_tval;
                state_nxt    = JUMP;
            end
            JUMP: begin
                // irq_pc_i already reflects the mcause written in SAVE.
                stall_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = irq_pc_i;
                state_nxt     = IDLE;
            end
            MRET: begin
                stall_o       = 1'b1;
                mret_ena_o    = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_i;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed table-driven bench for trap_ctrl
module tb_trap_ctrl;

    localparam int XLEN = 64;
    localparam logic [63:0] IRQ_PC = 64'h0000_0000_8000_0200;
    localparam logic [63:0] MEPC   = 64'h0000_0000_8000_0104;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ext_irq_i = 0, sft_irq_i = 0, tmr_irq_i = 0;
    logic            meie_i = 0, msie_i = 0, mtie_i = 0, glb_irq_i = 0;
    logic            cmt_valid_i = 0, exp_valid_i = 0, mret_i = 0;
    logic [XLEN-1:0] cmt_pc_i = '0, exp_tval_i = '0;
    logic [3:0]      exp_code_i = '0;
    logic [XLEN-1:0] irq_pc_i = IRQ_PC, mepc_i = MEPC;
    logic            kill_o, stall_o, trap_enter_o, mret_ena_o;
    logic            mepc_we_o, mcause_we_o, mtval_we_o, redirect_o;
    logic [XLEN-1:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;
    logic [2:0]      mip_o;

    int total = 0;
    int bad   = 0;

    trap_ctrl #(.XLEN(XLEN), .EXT_SYNC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i), .tmr_irq_i(tmr_irq_i),
        .meie_i(meie_i), .msie_i(msie_i), .mtie_i(mtie_i), .glb_irq_i(glb_irq_i),
        .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i),
        .exp_valid_i(exp_valid_i), .exp_code_i(exp_code_i), .exp_tval_i(exp_tval_i),
        .mret_i(mret_i), .irq_pc_i(irq_pc_i), .mepc_i(mepc_i),
        .kill_o(kill_o), .stall_o(stall_o), .trap_enter_o(trap_enter_o),
        .mret_ena_o(mret_ena_o), .mepc_we_o(mepc_we_o), .mepc_o(mepc_o),
        .mcause_we_o(mcause_we_o), .mcause_o(mcause_o),
        .mtval_we_o(mtval_we_o), .mtval_o(mtval_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .mip_o(mip_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ext, sft, tmr;
        logic [2:0]  en;      // {meie, mtie, msie}
        logic        glb, cv, exv;
        logic [3:0]  code;
        logic        mret;
        logic [63:0] pc, tval;
        logic        kill;
        int          kind;    // 0 nothing, 1 trap entry, 2 mret
        logic [63:0] mcause, mepc, mtval;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{kill_o, stall_o, trap_enter_o, mret_ena_o, mepc_we_o, mcause_we_o,
                 mtval_we_o, redirect_o, mip_o, mepc_o, mcause_o, mtval_o, redirect_pc_o};
    endfunction

    task automatic quiet();
        {ext_irq_i, sft_irq_i, tmr_irq_i} = '0;
        {meie_i, mtie_i, msie_i} = '0;
        glb_irq_i = 0; cmt_valid_i = 0; exp_valid_i = 0; mret_i = 0;
        cmt_pc_i = '0; exp_tval_i = '0; exp_code_i = '0;
    endtask

    initial begin
        string s;
        // ext sft tmr en glb cv exv code mret pc tval | kill kind mcause mepc mtval
        vec[0]  = '{0,0,1,3'b010,1,1,0,4'd0,0,64'h8000_0010,64'h0,    1,1,64'h8000_0000_0000_0007,64'h8000_0010,64'h0};
        vec[1]  = '{1,1,1,3'b111,1,1,1,4'd2,0,64'h8000_0020,64'hDEAD, 1,1,64'h8000_0000_0000_000B,64'h8000_0020,64'h0};
        vec[2]  = '{1,1,1,3'b111,0,1,1,4'd2,0,64'h8000_0020,64'hDEAD, 1,1,64'h2,64'h8000_0020,64'hDEAD};
        vec[3]  = '{0,0,0,3'b000,1,1,0,4'd0,1,64'h8000_0030,64'h0,    1,2,64'h0,64'h0,64'h0};
        vec[4]  = '{0,0,0,3'b000,1,1,1,4'd4,0,64'h8000_0003,64'h8000_0003, 1,1,64'h4,64'h8000_0002,64'h8000_0003};
        vec[5]  = '{0,1,0,3'b001,1,1,0,4'd0,0,64'h8000_0040,64'h0,    1,1,64'h8000_0000_0000_0003,64'h8000_0040,64'h0};
        vec[6]  = '{1,0,0,3'b100,1,1,0,4'd0,0,64'h8000_0050,64'h0,    1,1,64'h8000_0000_0000_000B,64'h8000_0050,64'h0};
        vec[7]  = '{0,0,1,3'b101,1,1,0,4'd0,0,64'h8000_0060,64'h0,    0,0,64'h0,64'h0,64'h0};
        vec[8]  = '{0,0,0,3'b000,1,1,1,4'd11,1,64'h8000_0070,64'h55,  1,1,64'hB,64'h8000_0070,64'h55};
        vec[9]  = '{0,1,0,3'b001,1,1,0,4'd0,1,64'h8000_0080,64'h0,    1,1,64'h8000_0000_0000_0003,64'h8000_0080,64'h0};
        vec[10] = '{0,0,1,3'b010,1,0,0,4'd0,0,64'h8000_0090,64'h0,    0,0,64'h0,64'h0,64'h0};

        quiet();
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", 64'(any_out()), 64'h0);
        rst_n = 1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ext_irq_i = vec[i].ext; sft_irq_i = vec[i].sft; tmr_irq_i = vec[i].tmr;
            {meie_i, mtie_i, msie_i} = vec[i].en;
            glb_irq_i = vec[i].glb;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_mip", i), 64'(mip_o), 64'({vec[i].ext, vec[i].tmr, vec[i].sft}));
            cmt_valid_i = vec[i].cv; cmt_pc_i = vec[i].pc;
            exp_valid_i = vec[i].exv; exp_code_i = vec[i].code; exp_tval_i = vec[i].tval;
            mret_i = vec[i].mret;
            #1;
            chk($sformatf("v%0d_kill", i), 64'(kill_o), 64'(vec[i].kill));
            @(negedge clk);
            quiet();
            #1;
            s = $sformatf("v%0d", i);
            if (vec[i].kind == 1) begin
                chk({s, "_save_we"}, 64'({mepc_we_o, mcause_we_o, mtval_we_o, trap_enter_o, stall_o, redirect_o}), 64'b111110);
                chk({s, "_mepc"},   mepc_o,   vec[i].mepc);
                chk({s, "_mcause"}, mcause_o, vec[i].mcause);
                chk({s, "_mtval"},  mtval_o,  vec[i].mtval);
                @(negedge clk); #1;
                chk({s, "_jump_str"}, 64'({redirect_o, stall_o, mepc_we_o, trap_enter_o}), 64'b1100);
                chk({s, "_jump_pc"}, redirect_pc_o, IRQ_PC);
            end else if (vec[i].kind == 2) begin
                chk({s, "_mret_str"}, 64'({mret_ena_o, redirect_o, stall_o, mepc_we_o, mcause_we_o, mtval_we_o, trap_enter_o}), 64'b1110000);
                chk({s, "_mret_pc"}, redirect_pc_o, MEPC);
            end else begin
                chk({s, "_idle"}, 64'(any_out()), 64'h0);
            end
            @(negedge clk); #1;
            chk({s, "_back_idle"}, 64'({stall_o, redirect_o, mret_ena_o, mepc_we_o}), 64'h0);
        end

        // pending interrupt but no commit for 5 cycles, then first commit takes it
        @(negedge clk);
        tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; cmt_pc_i = 64'h8000_00A0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("nocmt%0d", c), 64'({kill_o, stall_o, mepc_we_o}), 64'h0);
            @(negedge clk);
        end
        cmt_valid_i = 1; #1;
        chk("nocmt_take_kill", 64'(kill_o), 64'h1);
        // held interrupt: next entry no sooner than 3 cycles later
        @(negedge clk); #1;
        chk("space_t1_kill", 64'({kill_o, mepc_we_o}), 64'b01);
        @(negedge clk); #1;
        chk("space_t2_kill", 64'({kill_o, redirect_o}), 64'b01);
        @(negedge clk); #1;
        chk("space_t3_kill", 64'(kill_o), 64'h1);
        @(negedge clk); quiet();
        repeat (3) @(negedge clk);

        // external interrupt through the 2-flop synchroniser
        ext_irq_i = 1; meie_i = 1; glb_irq_i = 1; cmt_valid_i = 1; cmt_pc_i = 64'h8000_00B0;
        #1;
        chk("ext_sync0", 64'({mip_o[2], kill_o}), 64'b00);
        @(negedge clk); #1;
        chk("ext_sync1", 64'({mip_o[2], kill_o}), 64'b00);
        @(negedge clk); #1;
        chk("ext_sync2", 64'({mip_o[2], kill_o}), 64'b11);
        @(negedge clk); #1;
        chk("ext_cause", mcause_o, 64'h8000_0000_0000_000B);
        quiet();
        repeat (4) @(negedge clk);

        // asynchronous reset while in SAVE
        tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; cmt_valid_i = 1; cmt_pc_i = 64'h8000_00C0;
        @(negedge clk); #1;
        chk("rst_pre_save", 64'(mepc_we_o), 64'h1);
        #2 rst_n = 0; #1;
        chk("rst_mid_all0", 64'(any_out()), 64'h0);
        @(negedge clk);
        quiet();
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rst_after%0d", c), 64'({redirect_o, stall_o, mepc_we_o}), 64'h0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
